fpu_minmax_ctrl: RTL and testbench
==================================

Name: fpu_minmax_ctrl

Overview:
Front-end controller that shares one fpu_min_max datapath between two requesters: port 0 is the core FP issue stage, port 1 is the reduction/accelerator port. It arbitrates round-robin, classifies the operands, sequences the datapath through a fixed multi-cycle FSM, and returns a tagged result over a valid/ready response channel. It also keeps a sticky NV (invalid) exception flag for fflags.

Parameters:
TAG_W, 3, width of the requester tag that is echoed back with the response

Ports:
clk_i  input  1  clock
reset_i  input  1  asynchronous reset, active-low
req0_valid_i  input  1  port 0 request valid
req0_ready_o  output  1  port 0 request accepted this cycle
req0_op_i  input  1  0=FMIN, 1=FMAX
req0_a_i  input  32  operand A, IEEE-754 single
req0_b_i  input  32  operand B
req0_tag_i  input  TAG_W  port 0 tag
req1_valid_i, req1_ready_o, req1_op_i, req1_a_i, req1_b_i, req1_tag_i  same as port 0, for port 1
resp_valid_o  output  1  result valid
resp_ready_i  input  1  consumer accepts the result
resp_data_o  output  32  min/max result
resp_src_o  output  1  requester index (0/1)
resp_tag_o  output  TAG_W  echoed tag
resp_nv_o  output  1  per-op invalid flag (signaling NaN input)
fflags_nv_o  output  1  sticky NV
fflags_clr_i  input  1  clear sticky NV

Behaviour:
- Reset (reset_i low, asynchronous): state=IDLE; resp_valid_o=0, resp_data_o=0, resp_src_o=0, resp_tag_o=0, resp_nv_o=0, fflags_nv_o=0, last_grant=1 (so port 0 wins the first tie). Any in-flight operation is dropped and never responded to.
- FSM: IDLE -> CLASS -> EXEC -> RESP -> IDLE. Only one operation is in flight at a time.
- IDLE arbitration:
  - If exactly one reqN_valid_i is high, that port is granted.
  - If both are high, grant the port that is not last_grant, then update last_grant.
  - reqN_ready_o = (state==IDLE) & grantN. This is combinational, and both ready outputs are 0 in every other state.
  - On the handshake: capture op, A, B, src, tag, then go to CLASS.
- CLASS: register, for each operand:
  - isNaN = exp==8'hFF & frac!=0
  - isSignaling = isNaN & frac[22]==0
  - isInf = exp==8'hFF & frac==0
  - sig = {exp!=0, frac}
  - Signaling is the OR over both operands.
- EXEC: drive the datapath with the registered fields (min_or_max = op). Register min_max_out into resp_data_o and invalid into resp_nv_o, set resp_valid_o=1, go to RESP.
- Datapath semantics the controller relies on:
  - Both NaN -> 32'h7FC00000.
  - Single NaN -> the other operand.
  - +0 is greater than -0.
  - Equal operands: max returns A, min returns B.
- RESP:
  - Hold resp_* stable while resp_valid_o=1 & resp_ready_i=0.
  - On handshake: resp_valid_o=0, go to IDLE. A new request cannot be accepted in that same cycle.
- Latency: request accepted at cycle T -> resp_valid_o high at T+3. Maximum throughput is one op per 4 cycles with resp_ready_i tied high.
- Sticky NV:
  - Set on the EXEC->RESP transition when invalid=1.
  - fflags_clr_i clears it.
  - If a set and a clear happen in the same cycle, the set wins.
- A request that is not granted keeps waiting. Requesters must hold valid and payload stable until ready. Starvation is impossible: the losing port wins the next tie.

Test Plan:
- Port 0 FMIN A=3F800000 (1.0), B=C0000000 (-2.0), tag=5 -> resp_valid at T+3, data=C0000000, src=0, tag=5, nv=0.
- FMAX A=00000000, B=80000000 -> 00000000; FMIN with the same operands -> 80000000. Equal operands FMAX A=B=40400000 -> 40400000.
- FMAX A=7FC00000, B=7F800001 (both NaN) -> 7FC00000, nv=1, fflags_nv_o=1 from that point. FMAX A=7F800001, B=3F800000 -> 3F800000, nv=1. FMIN A=7FC00000, B=40000000 -> 40000000, nv=0.
- Both ports valid continuously, resp_ready_i=1 -> grants alternate 0,1,0,1. Responses arrive every 4 cycles with the matching src/tag.
- resp_ready_i held low 5 cycles in RESP -> data/src/tag stable, both ready outputs 0. Assert fflags_clr_i in the same cycle as an NV-setting EXEC -> fflags_nv_o stays 1.
- Drop reset_i while in EXEC -> all outputs 0 immediately. After release, a port 1 only request is granted and no stale response appears.

Source files
------------

// File: rtl/fpu_minmax_ctrl_if.sv
// Request/response bundle between the two FP requesters, the result consumer
// and the shared min/max controller. The controller takes the slave view.
interface fpu_minmax_ctrl_if #(
  parameter int TAG_W = 3
);
  // Port 0: core FP issue stage
  logic             req0_valid_i;
  logic             req0_ready_o;
  logic             req0_op_i;
  logic [31:0]      req0_a_i;
  logic [31:0]      req0_b_i;
  logic [TAG_W-1:0] req0_tag_i;
  // Port 1: reduction/accelerator port
  logic             req1_valid_i;
  logic             req1_ready_o;
  logic             req1_op_i;
  logic [31:0]      req1_a_i;
  logic [31:0]      req1_b_i;
  logic [TAG_W-1:0] req1_tag_i;
  // Response channel
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [31:0]      resp_data_o;
  logic             resp_src_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic             resp_nv_o;
  // Exception flags
  logic             fflags_nv_o;
  logic             fflags_clr_i;

  modport slave (
    input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i, req0_tag_i,
    input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_tag_i,
    input  resp_ready_i, fflags_clr_i,
    output req0_ready_o, req1_ready_o,
    output resp_valid_o, resp_data_o, resp_src_o, resp_tag_o, resp_nv_o,
    output fflags_nv_o
  );

  modport master (
    output req0_valid_i, req0_op_i, req0_a_i, req0_b_i, req0_tag_i,
    output req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_tag_i,
    output resp_ready_i, fflags_clr_i,
    input  req0_ready_o, req1_ready_o,
    input  resp_valid_o, resp_data_o, resp_src_o, resp_tag_o, resp_nv_o,
    input  fflags_nv_o
  );
endinterface

// File: rtl/fpu_minmax_ctrl.sv
// Shared FMIN/FMAX front end: round-robin arbitration between two requesters,
// operand classification, a fixed IDLE->CLASS->EXEC->RESP sequence around the
// min/max datapath, a tagged valid/ready response and a sticky NV flag.
module fpu_minmax_ctrl #(
  parameter int TAG_W = 3
) (
  input logic             clk_i,
  input logic             reset_i,
  fpu_minmax_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLASS, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             grant0, grant1, accept;
  logic             last_grant;

  // Captured request
  logic             op_q, src_q;
  logic [31:0]      a_q, b_q;
  logic [TAG_W-1:0] tag_q;

  // Registered operand classification
  logic             nan_a, nan_b, inf_a, inf_b, snan_q;
  logic [23:0]      sig_a, sig_b;

  // Datapath
  logic [31:0]      a_mag, b_mag, dp_out;
  logic             mag_eq, mag_lt, a_lt_b;

  // State register
  always_ff @(posedge clk_i or negedge reset_i) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and arbitration; grants are only ever non-zero in IDLE
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0_valid_i && bus.req1_valid_i) begin
          grant0 = last_grant;
          grant1 = ~last_grant;
        end else begin
          grant0 = bus.req0_valid_i;
          grant1 = bus.req1_valid_i;
        end
        if (grant0 || grant1) state_nxt = CLASS;
      end
      CLASS:   state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.resp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req0_ready_o = grant0;
  assign bus.req1_ready_o = grant1;
  assign accept           = grant0 | grant1;

  // Round-robin pointer: only a tie moves it, so the loser wins the next tie
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) last_grant <= 1'b1;
    else if (state == IDLE && bus.req0_valid_i && bus.req1_valid_i)
      last_grant <= grant1;
  end

  // Request capture and operand classification
  always_ff @(posedge clk_i) begin
    // NOTE: payload/class flops have no reset; they are always written before use.
    if (accept) begin
      op_q  <= grant1 ? bus.req1_op_i  : bus.req0_op_i;
      a_q   <= grant1 ? bus.req1_a_i   : bus.req0_a_i;
      b_q   <= grant1 ? bus.req1_b_i   : bus.req0_b_i;
      tag_q <= grant1 ? bus.req1_tag_i : bus.req0_tag_i;
      src_q <= grant1;
    end
    if (state == CLASS) begin
      nan_a  <= (a_q[30:23] == 8'hFF) && (a_q[22:0] != '0);
      nan_b  <= (b_q[30:23] == 8'hFF) && (b_q[22:0] != '0);
      inf_a  <= (a_q[30:23] == 8'hFF) && (a_q[22:0] == '0);
      inf_b  <= (b_q[30:23] == 8'hFF) && (b_q[22:0] == '0);
      sig_a  <= {a_q[30:23] != 8'h00, a_q[22:0]};
      sig_b  <= {b_q[30:23] != 8'h00, b_q[22:0]};
      snan_q <= ((a_q[30:23] == 8'hFF) && (a_q[22:0] != '0) && !a_q[22]) ||
                ((b_q[30:23] == 8'hFF) && (b_q[22:0] != '0) && !b_q[22]);
    end
  end

  // Min/max datapath: +0 > -0, equal operands give A for max and B for min
  always_comb begin
    a_mag  = {a_q[30:23], sig_a};
    b_mag  = {b_q[30:23], sig_b};
    mag_eq = (a_mag == b_mag) || (inf_a && inf_b);
    mag_lt = !mag_eq && (a_mag < b_mag);
    if (a_q[31] != b_q[31]) a_lt_b = a_q[31];
    else if (!a_q[31])      a_lt_b = mag_lt;
    else                    a_lt_b = !mag_eq && !mag_lt;
    if (nan_a && nan_b)     dp_out = 32'h7FC0_0000;
    else if (nan_a)         dp_out = b_q;
    else if (nan_b)         dp_out = a_q;
    else if (op_q)          dp_out = a_lt_b ? b_q : a_q;
    else                    dp_out = a_lt_b ? a_q : b_q;
  end

  // Response registers: loaded leaving EXEC, held while RESP is stalled
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      bus.resp_valid_o <= 1'b0;
      bus.resp_data_o  <= '0;
      bus.resp_src_o   <= 1'b0;
      bus.resp_tag_o   <= '0;
      bus.resp_nv_o    <= 1'b0;
    end else if (state == EXEC) begin
      bus.resp_valid_o <= 1'b1;
      bus.resp_data_o  <= dp_out;
      bus.resp_src_o   <= src_q;
      bus.resp_tag_o   <= tag_q;
      bus.resp_nv_o    <= snan_q;
    end else if (state == RESP && bus.resp_ready_i) begin
      bus.resp_valid_o <= 1'b0;
    end
  end

  // Sticky NV: a set leaving EXEC takes priority over a same-cycle clear
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)                     bus.fflags_nv_o <= 1'b0;
    else if (state == EXEC && snan_q) bus.fflags_nv_o <= 1'b1;
    else if (bus.fflags_clr_i)        bus.fflags_nv_o <= 1'b0;
  end

endmodule

// File: tb/tb_fpu_minmax_ctrl.sv
// Directed bench for fpu_minmax_ctrl: hand-computed FMIN/FMAX results,
// latency, arbitration fairness, backpressure, sticky NV and async reset.
module tb_fpu_minmax_ctrl;
  localparam int TAG_W = 3;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  fpu_minmax_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fpu_minmax_ctrl #(.TAG_W(TAG_W)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input bit p);
    return p ? bus.req1_ready_o : bus.req0_ready_o;
  endfunction

  task automatic drive(input bit p, input bit v, input bit op,
                       input logic [31:0] a, input logic [31:0] b, input logic [2:0] tag);
    if (!p) begin
      bus.req0_valid_i = v; bus.req0_op_i = op;
      bus.req0_a_i = a; bus.req0_b_i = b; bus.req0_tag_i = tag;
    end else begin
      bus.req1_valid_i = v; bus.req1_op_i = op;
      bus.req1_a_i = a; bus.req1_b_i = b; bus.req1_tag_i = tag;
    end
  endtask

  // One request on port p, response expected exactly 3 cycles after acceptance.
  task automatic run_op(input string name, input bit p, input bit op,
                        input logic [31:0] a, input logic [31:0] b, input logic [2:0] tag,
                        input logic [31:0] exp_d, input bit exp_nv, input bit clr_in_exec);
    int n;
    @(negedge clk);
    drive(p, 1'b1, op, a, b, tag);
    #1;
    n = 0;
    while (!rdy(p) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    check({name, " accept"}, {31'b0, rdy(p)}, 32'd1);
    @(negedge clk);
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    n = 1;
    while (!bus.resp_valid_o && n < 10) begin
      @(negedge clk);
      n++;
      if (n == 2 && clr_in_exec) bus.fflags_clr_i = 1'b1;
    end
    bus.fflags_clr_i = 1'b0;
    check({name, " latency"}, 32'(n), 32'd3);
    check({name, " data"}, bus.resp_data_o, exp_d);
    check({name, " src"}, {31'b0, bus.resp_src_o}, {31'b0, p});
    check({name, " tag"}, {29'b0, bus.resp_tag_o}, {29'b0, tag});
    check({name, " nv"}, {31'b0, bus.resp_nv_o}, {31'b0, exp_nv});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen, cyc, last_cyc, n;
    bit exp_src;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    bus.resp_ready_i = 1'b1;
    bus.fflags_clr_i = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst resp_valid", {31'b0, bus.resp_valid_o}, 32'd0);
    check("rst resp_data", bus.resp_data_o, 32'h0);
    check("rst resp_tag", {29'b0, bus.resp_tag_o}, 32'd0);
    check("rst fflags", {31'b0, bus.fflags_nv_o}, 32'd0);
    @(negedge clk);
    reset_i = 1'b1;

    // Basic results
    run_op("fmin_basic", 1'b0, 1'b0, 32'h3F800000, 32'hC0000000, 3'd5, 32'hC0000000, 1'b0, 1'b0);
    run_op("fmax_zero",  1'b0, 1'b1, 32'h00000000, 32'h80000000, 3'd1, 32'h00000000, 1'b0, 1'b0);
    run_op("fmin_zero",  1'b1, 1'b0, 32'h00000000, 32'h80000000, 3'd2, 32'h80000000, 1'b0, 1'b0);
    run_op("fmax_eq",    1'b0, 1'b1, 32'h40400000, 32'h40400000, 3'd3, 32'h40400000, 1'b0, 1'b0);
    run_op("fmax_neg",   1'b1, 1'b1, 32'hC0000000, 32'hBF800000, 3'd0, 32'hBF800000, 1'b0, 1'b0);
    run_op("fmin_mag",   1'b0, 1'b0, 32'h40000000, 32'h3F800000, 3'd1, 32'h3F800000, 1'b0, 1'b0);
    check("nv still clear", {31'b0, bus.fflags_nv_o}, 32'd0);

    // NaN handling and sticky NV
    run_op("fmax_2nan",  1'b0, 1'b1, 32'h7FC00000, 32'h7F800001, 3'd4, 32'h7FC00000, 1'b1, 1'b0);
    check("nv sticky set", {31'b0, bus.fflags_nv_o}, 32'd1);
    run_op("fmax_snan",  1'b1, 1'b1, 32'h7F800001, 32'h3F800000, 3'd6, 32'h3F800000, 1'b1, 1'b0);
    run_op("fmin_qnan",  1'b0, 1'b0, 32'h7FC00000, 32'h40000000, 3'd7, 32'h40000000, 1'b0, 1'b0);
    check("nv sticky hold", {31'b0, bus.fflags_nv_o}, 32'd1);
    @(negedge clk); bus.fflags_clr_i = 1'b1;
    @(negedge clk); bus.fflags_clr_i = 1'b0;
    #1;
    check("nv cleared", {31'b0, bus.fflags_nv_o}, 32'd0);

    // Both ports valid continuously: grants alternate 0,1,0,1 every 4 cycles
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h3F800000, 32'h40000000, 3'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h3F800000, 32'h40000000, 3'd6);
    seen = 0; cyc = 0; last_cyc = 0;
    while (seen < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.resp_valid_o) begin
        exp_src = seen[0];
        check("rr src", {31'b0, bus.resp_src_o}, {31'b0, exp_src});
        check("rr tag", {29'b0, bus.resp_tag_o}, exp_src ? 32'd6 : 32'd1);
        check("rr data", bus.resp_data_o, exp_src ? 32'h3F800000 : 32'h40000000);
        if (seen > 0) check("rr interval", 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
        seen++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    check("rr count", 32'(seen), 32'd4);

    // Backpressure: response held for 5 cycles, no request accepted meanwhile
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'hC0000000, 32'hBF800000, 3'd2);
    #1;
    check("bp accept", {31'b0, bus.req0_ready_o}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h3F800000, 32'h0, 3'd7);
    n = 0;
    while (!bus.resp_valid_o && n < 10) begin
      @(negedge clk); n++;
    end
    check("bp resp seen", {31'b0, bus.resp_valid_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp valid", {31'b0, bus.resp_valid_o}, 32'd1);
      check("bp data", bus.resp_data_o, 32'hC0000000);
      check("bp src", {31'b0, bus.resp_src_o}, 32'd0);
      check("bp tag", {29'b0, bus.resp_tag_o}, 32'd2);
      check("bp ready", {30'b0, bus.req1_ready_o, bus.req0_ready_o}, 32'd0);
    end
    bus.resp_ready_i = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    check("bp released", {31'b0, bus.resp_valid_o}, 32'd0);

    // Set and clear of NV in the same cycle: set wins
    run_op("clr_race", 1'b0, 1'b0, 32'h7F800001, 32'h3F800000, 3'd3, 32'h3F800000, 1'b1, 1'b1);
    check("nv set beats clr", {31'b0, bus.fflags_nv_o}, 32'd1);

    // Asynchronous reset while the operation sits in EXEC
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h40000000, 32'h3F800000, 3'd5);
    #1;
    check("rst op accept", {31'b0, bus.req0_ready_o}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    #2 reset_i = 1'b0;
    #1;
    check("exec rst valid", {31'b0, bus.resp_valid_o}, 32'd0);
    check("exec rst data", bus.resp_data_o, 32'h0);
    check("exec rst tag", {29'b0, bus.resp_tag_o}, 32'd0);
    check("exec rst nv", {30'b0, bus.resp_src_o, bus.resp_nv_o}, 32'd0);
    check("exec rst fflags", {31'b0, bus.fflags_nv_o}, 32'd0);
    @(negedge clk);
    reset_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no stale resp", {31'b0, bus.resp_valid_o}, 32'd0);
    end
    run_op("p1_after_rst", 1'b1, 1'b1, 32'h40000000, 32'h3F800000, 3'd4, 32'h40000000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
